// File: rtl/mcounter_pkg.sv
// Shared definitions for the multi-mode counter: mode encodings and the
// binary-to-Gray helper used by the encoder.
package mcounter_pkg;

   localparam int MAX_W = 64;

   typedef enum logic [1:0] {
      MODE_BIN_UP   = 2'b00,
      MODE_BIN_DOWN = 2'b01,
      MODE_GRAY_UP  = 2'b10,
      MODE_HOLD     = 2'b11
   } mode_e;

   // Operates on the widest legal count; callers cast to their own width.
   function automatic logic [MAX_W-1:0] bin2gray(input logic [MAX_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

endpackage

// File: rtl/mcounter_gray_enc.sv
// Combinational WIDTH-bit binary-to-Gray encoder.
module mcounter_gray_enc
   import mcounter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] bin,
   output logic [WIDTH-1:0] gray
);

   assign gray = WIDTH'(bin2gray(MAX_W'(bin)));

endmodule

// File: rtl/mcounter.sv
// Multi-mode counter: binary up/down or Gray-coded up, with load, enable,
// wrap/saturate limit behaviour and a registered terminal-count flag.
module mcounter
   import mcounter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter bit WRAP  = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   input  logic [1:0]       mode,
   output logic [WIDTH-1:0] q,
   output logic             tc
);

   localparam logic [WIDTH-1:0] ONES = '1;

   logic [WIDTH-1:0] cnt;
   logic [WIDTH-1:0] cnt_next;
   logic [WIDTH-1:0] gray_next;
   logic [WIDTH-1:0] q_next;
   logic             tc_next;

   function automatic logic [WIDTH-1:0] step_up(input logic [WIDTH-1:0] x);
      if (!WRAP && x == ONES) return x;
      return x + 1'b1;
   endfunction

   function automatic logic [WIDTH-1:0] step_down(input logic [WIDTH-1:0] x);
      if (!WRAP && x == '0) return x;
      return x - 1'b1;
   endfunction

   // Load has priority over counting and is never limited by saturation.
   always_comb begin
      cnt_next = cnt;
      if (load) begin
         cnt_next = d;
      end else if (en) begin
         case (mode)
            MODE_BIN_UP, MODE_GRAY_UP: cnt_next = step_up(cnt);
            MODE_BIN_DOWN:             cnt_next = step_down(cnt);
            default:                   cnt_next = cnt;
         endcase
      end
   end

   mcounter_gray_enc #(.WIDTH(WIDTH)) u_gray_enc (
      .bin  (cnt_next),
      .gray (gray_next)
   );

   // Output encoding and terminal flag follow the mode sampled this edge,
   // so a mode change alone re-encodes q and re-evaluates tc.
   always_comb begin
      q_next  = (mode == MODE_GRAY_UP) ? gray_next : cnt_next;
      tc_next = 1'b0;
      case (mode)
         MODE_BIN_UP, MODE_GRAY_UP: tc_next = (cnt_next == ONES);
         MODE_BIN_DOWN:             tc_next = (cnt_next == '0);
         default:                   tc_next = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt <= '0;
         q   <= '0;
         tc  <= 1'b0;
      end else begin
         cnt <= cnt_next;
         q   <= q_next;
         tc  <= tc_next;
      end
   end

endmodule

// File: tb/tb_mcounter.sv
module tb_mcounter;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic       load;
  logic [3:0] d;
  logic [1:0] mode;
  logic [3:0] q_w, q_s;
  logic       tc_w, tc_s;

  int n_cmp = 0;
  int n_bad = 0;

  int mcnt[2];
  int mq[2];
  bit mtc[2];

  always #5 clk = ~clk;

  mcounter #(.WIDTH(4), .WRAP(1'b1)) u_wrap (
    .clk(clk), .reset(reset), .en(en), .load(load), .d(d), .mode(mode),
    .q(q_w), .tc(tc_w)
  );

  mcounter #(.WIDTH(4), .WRAP(1'b0)) u_sat (
    .clk(clk), .reset(reset), .en(en), .load(load), .d(d), .mode(mode),
    .q(q_s), .tc(tc_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".wrap.q"},  32'(q_w),  32'(mq[0]));
    chk({tag, ".wrap.tc"}, 32'(tc_w), 32'(mtc[0]));
    chk({tag, ".sat.q"},   32'(q_s),  32'(mq[1]));
    chk({tag, ".sat.tc"},  32'(tc_s), 32'(mtc[1]));
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0;
      mq[k]   = 0;
      mtc[k]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int c;
      c = mcnt[k];
      if (load) begin
        c = int'(d);
      end else if (en && (mode == 2'd0 || mode == 2'd2)) begin
        c = (k == 0) ? (c + 1) % 16 : ((c + 1 > 15) ? 15 : c + 1);
      end else if (en && mode == 2'd1) begin
        c = (k == 0) ? (c + 15) % 16 : ((c - 1 < 0) ? 0 : c - 1);
      end
      mcnt[k] = c;
      mq[k]   = (mode == 2'd2) ? (c ^ (c / 2)) : c;
      mtc[k]  = ((mode == 2'd0 || mode == 2'd2) && c == 15) || (mode == 2'd1 && c == 0);
    end
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    if (reset) model_reset();
    else       model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic async_reset_pulse(input string tag);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #1 reset = 1'b0;
  endtask

  initial begin
    logic [3:0] prev_q;
    reset = 1'b1; en = 1'b1; load = 1'b0; d = '0; mode = 2'd0;
    model_reset();

    for (int i = 0; i < 3; i++) tick("reset");
    reset = 1'b0;

    for (int i = 0; i < 17; i++) tick("binup");

    async_reset_pulse("rst_gray");
    mode = 2'd2;
    prev_q = q_w;
    for (int i = 0; i < 16; i++) begin
      tick("gray");
      chk("gray.onebit", 32'($countones(q_w ^ prev_q)), 32'd1);
      prev_q = q_w;
    end

    mode = 2'd0; en = 1'b0; load = 1'b1; d = 4'd14;
    tick("load14");
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 3; i++) tick("sat_up");

    mode = 2'd1; en = 1'b0; load = 1'b1; d = 4'd1;
    tick("load1");
    load = 1'b0; en = 1'b1;
    for (int i = 0; i < 2; i++) tick("sat_dn");

    mode = 2'd0; load = 1'b1; en = 1'b1; d = 4'd9;
    tick("load_en");
    chk("load_en.abs", 32'(q_w), 32'd9);
    load = 1'b0;
    tick("after_load");
    chk("after_load.abs", 32'(q_w), 32'd10);

    load = 1'b1; en = 1'b0; d = 4'd4;
    tick("load4");
    load = 1'b0; en = 1'b1;
    tick("to5");
    mode = 2'd2; en = 1'b0;
    tick("regray");
    chk("regray.abs", 32'(q_w), 32'b0111);
    mode = 2'd3; en = 1'b1;
    tick("hold1");
    tick("hold2");
    chk("hold.abs", 32'(q_w), 32'd5);

    mode = 2'd0; load = 1'b1; en = 1'b0; d = 4'd6;
    tick("load6");
    load = 1'b0; en = 1'b1;
    tick("to7");
    async_reset_pulse("rst_mid");
    tick("resume");
    chk("resume.abs", 32'(q_w), 32'd1);

    async_reset_pulse("rst_dn");
    mode = 2'd1;
    tick("dn_first");

    for (int i = 0; i < 400; i++) begin
      en   = ($urandom_range(0, 3) != 0);
      load = ($urandom_range(0, 9) == 0);
      d    = 4'($urandom_range(0, 15));
      mode = 2'($urandom_range(0, 3));
      tick("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mcounter.md
# mcounter

Parametrised multi-mode counter; the next-generation replacement for the fixed 32-bit binary counter in the counter-power study. It counts up or down in binary, or counts up with a Gray-coded output to cut output toggle activity. It supports enable, synchronous load, wrap or saturate at the limits, and a registered terminal-count flag. It is a standalone leaf, driven by the gate-level and SDF-annotated power benches.

## Interface
- WIDTH, 32: counter and output width; legal range 2..64.
- WRAP, 1: 1 = wrap at limits, 0 = saturate at limits.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- en  input  1  count enable.
- load  input  1  synchronous load strobe; overrides en.
- d  input  WIDTH  load value, always binary.
- mode  input  2  00 BIN_UP, 01 BIN_DOWN, 10 GRAY_UP, 11 HOLD (reserved).
- q  output  WIDTH  registered count; binary in 00/01/11, Gray of count in 10.
- tc  output  1  registered terminal-count flag.

## Operation
- Internal binary state cnt[WIDTH-1:0].
- cnt_next is set by the first matching rule:
  - load=1: d.
  - en=1, BIN_UP or GRAY_UP: cnt+1.
  - en=1, BIN_DOWN: cnt-1.
  - otherwise (including HOLD): cnt.
- Arithmetic is modulo 2^WIDTH; there is no carry-out port.
- WRAP=0: up at all-ones holds all-ones; down at zero holds zero.
- WRAP=0 does not restrict load: any d is accepted.
- q register is loaded every cycle with encode(cnt_next, mode).
  - In GRAY_UP, encode is the Gray code of cnt_next, x ^ (x>>1); in every other mode it is cnt_next unchanged.
- Terminal value: all-ones for BIN_UP/GRAY_UP, zero for BIN_DOWN, none for HOLD.
- tc register is loaded every cycle with (cnt_next == terminal value of current mode).
- Mode change mid-count does not alter cnt. On the next edge, q is re-encoded and tc re-evaluated under the new mode, even if en=0.
- Reset values: cnt=0, q=0, tc=0. This holds regardless of mode.

## Timing
- Zero-cycle latency relative to cnt: q and tc always reflect the state written at the same edge.
- One clock edge from en/load/mode sampled to the q/tc update.
- reset asserted at any point clears cnt, q and tc asynchronously, without waiting for clk.
- On reset deassertion, the first active edge counts from 0. Example: BIN_DOWN with en=1 gives q=all-ones under WRAP=1, or q=0 with tc=1 under WRAP=0.
- load and en both high: load wins, and the count is not applied to d.
- Wrap boundary, BIN_UP and WRAP=1:
  - Edge entering all-ones sets tc=1.
  - Next enabled edge gives q=0, tc=0.
- GRAY_UP: exactly one bit of q toggles per enabled edge, including the wrap from all-ones to zero.
- With en=0 and load=0, q and tc are stable; the only exception is a mode change.

## Structure
- Shared package/include mcounter_pkg holds:
  - mode encodings: MODE_BIN_UP=2'b00, MODE_BIN_DOWN=2'b01, MODE_GRAY_UP=2'b10, MODE_HOLD=2'b11;
  - a parameterised bin2gray function.
- One natural sub-module, gray_enc: a combinational WIDTH-bit binary-to-Gray encoder, instantiated on cnt_next.
- Everything else is one always block for cnt/q/tc with async reset, plus combinational next-state logic.
- The existing bench structure is reused: a 10-time-unit clock, with the optional USE_SDF annotation guard against the mcounter instance.

## Test plan
- WIDTH=4, WRAP=1, BIN_UP, en=1 after 3 reset cycles -> q=1,2,...,15 with tc=1 at 15, then q=0 with tc=0; q=0 and tc=0 throughout reset.
- WIDTH=4, GRAY_UP, en=1 for 16 edges -> q follows 0001,0011,0010,0110,...,1000,0000; exactly one bit changes per edge.
- WIDTH=4, WRAP=0:
  - BIN_UP with load d=14 then en -> q=14,15,15,15 with tc=1 from the first 15.
  - BIN_DOWN from d=1 -> q=0,0 with tc=1.
- load=1, en=1, d=9, BIN_UP -> q=9, not 10; next edge with en only -> q=10.
- Counting BIN_UP at cnt=5 (q=0101), switch to GRAY_UP with en=0 -> next edge q=0111 (Gray of 5), cnt unchanged; switch to HOLD with en=1 -> q=5 frozen, tc=0.
- reset asserted between edges while counting at q=7 -> q=0 and tc=0 immediately, before the next clk edge; counting resumes from 1 after release.
